// File: rtl/pipe_reg_execute.sv
// pipe_reg_execute: decode-to-execute pipeline register for the vector CPU.
// Moves opcode, scalar and vector operands, immediate and write-back index
// across the stage boundary with a valid/ready handshake. State changes on the
// falling clock edge. Flush inserts a NOP bubble. A saturating counter records
// the cycles in which the held instruction was not consumed.
// Build option: define PIPE_REG_EXECUTE_SKID_EN to add a second skid entry.
// This makes in_ready a registered signal, so it no longer depends on out_ready.
module pipe_reg_execute #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned IMM_W  = 8,
   parameter int unsigned LANES  = 4,
   parameter int unsigned ELEM_W = 16,
   parameter int unsigned WB_W   = 3,
   parameter logic [4:0]  NOP_OP = 5'b11110
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4:0]              d_opcode,
   input  logic [XLEN-1:0]         d_reg1_data,
   input  logic [XLEN-1:0]         d_reg2_data,
   input  logic [IMM_W-1:0]        d_immediate,
   input  logic [LANES*ELEM_W-1:0] d_vec1_data,
   input  logic [LANES*ELEM_W-1:0] d_vec2_data,
   input  logic [WB_W-1:0]         d_wb_register,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [4:0]              q_opcode,
   output logic [XLEN-1:0]         q_reg1_data,
   output logic [XLEN-1:0]         q_reg2_data,
   output logic [IMM_W-1:0]        q_immediate,
   output logic [LANES*ELEM_W-1:0] q_vec1_data,
   output logic [LANES*ELEM_W-1:0] q_vec2_data,
   output logic [WB_W-1:0]         q_wb_register,
   output logic [15:0]             stall_count
);

   localparam int unsigned VW = LANES * ELEM_W;
   localparam int unsigned PW = 5 + 2 * XLEN + IMM_W + 2 * VW + WB_W;
   // An empty stage shows the NOP opcode and a zero payload.
   localparam logic [PW-1:0] EMPTY_PL = {NOP_OP, {(PW-5){1'b0}}};

   logic [PW-1:0] d_pl_s;
   logic [PW-1:0] main_q;
   logic [PW-1:0] main_d;
   logic          valid_q;
   logic          valid_d;
   logic          rdy_en_q;
   logic [15:0]   stall_q;
   logic [15:0]   stall_d;
   logic          in_xfer_s;
   logic          out_xfer_s;

   assign d_pl_s = {d_opcode, d_reg1_data, d_reg2_data, d_immediate,
                    d_vec1_data, d_vec2_data, d_wb_register};

   assign {q_opcode, q_reg1_data, q_reg2_data, q_immediate,
           q_vec1_data, q_vec2_data, q_wb_register} = main_q;
   assign out_valid   = valid_q;
   assign stall_count = stall_q;

`ifdef PIPE_REG_EXECUTE_SKID_EN
   logic [PW-1:0] skid_q;
   logic [PW-1:0] skid_d;
   logic          skid_valid_q;
   logic          skid_valid_d;

   // in_ready depends only on state and flush. out_ready is not used here.
   assign in_ready = rdy_en_q & ~skid_valid_q & ~flush;
`else
   // A single register can accept when it is empty or is being drained.
   assign in_ready = rdy_en_q & (~valid_q | out_ready) & ~flush;
`endif

   assign in_xfer_s  = in_valid & in_ready;
   assign out_xfer_s = valid_q & out_ready;

   // Next-state logic: flush, then fill and drain of the stage entries, then the stall counter.
   always_comb begin
      main_d  = main_q;
      valid_d = valid_q;
`ifdef PIPE_REG_EXECUTE_SKID_EN
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
`endif
      if (valid_q && !out_ready && !flush && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end else begin
         stall_d = stall_q;
      end

      if (flush) begin
         main_d  = EMPTY_PL;
         valid_d = 1'b0;
`ifdef PIPE_REG_EXECUTE_SKID_EN
         skid_valid_d = 1'b0;
`endif
      end else begin
`ifdef PIPE_REG_EXECUTE_SKID_EN
         if (out_xfer_s) begin
            if (skid_valid_q) begin
               // A full skid entry blocks input, so only the older skid entry moves to main.
               main_d       = skid_q;
               valid_d      = 1'b1;
               skid_valid_d = 1'b0;
            end else if (in_xfer_s) begin
               main_d  = d_pl_s;
               valid_d = 1'b1;
            end else begin
               main_d  = EMPTY_PL;
               valid_d = 1'b0;
            end
         end else if (in_xfer_s) begin
            if (valid_q) begin
               skid_d       = d_pl_s;
               skid_valid_d = 1'b1;
            end else begin
               main_d  = d_pl_s;
               valid_d = 1'b1;
            end
         end else begin
            main_d  = main_q;
            valid_d = valid_q;
         end
`else
         if (in_xfer_s) begin
            main_d  = d_pl_s;
            valid_d = 1'b1;
         end else if (out_xfer_s) begin
            main_d  = EMPTY_PL;
            valid_d = 1'b0;
         end else begin
            main_d  = main_q;
            valid_d = valid_q;
         end
`endif
      end
   end

   // Stage state register. It updates on the falling edge and resets asynchronously.
   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_q   <= EMPTY_PL;
         valid_q  <= 1'b0;
         stall_q  <= 16'd0;
         rdy_en_q <= 1'b0;
      end else begin
         main_q   <= main_d;
         valid_q  <= valid_d;
         stall_q  <= stall_d;
         rdy_en_q <= 1'b1;
      end
   end

`ifdef PIPE_REG_EXECUTE_SKID_EN
   // Skid entry register. It holds the instruction accepted while main is stalled.
   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         skid_q       <= {PW{1'b0}};
         skid_valid_q <= 1'b0;
      end else begin
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_reg_execute.sv
// Directed testbench for pipe_reg_execute with the default parameters.
// The DUT updates on the falling edge. The bench drives inputs and samples outputs
// 1 time unit after each rising edge.
module tb_pipe_reg_execute;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  d_opcode;
   logic [31:0] d_reg1_data;
   logic [31:0] d_reg2_data;
   logic [7:0]  d_immediate;
   logic [63:0] d_vec1_data;
   logic [63:0] d_vec2_data;
   logic [2:0]  d_wb_register;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  q_opcode;
   logic [31:0] q_reg1_data;
   logic [31:0] q_reg2_data;
   logic [7:0]  q_immediate;
   logic [63:0] q_vec1_data;
   logic [63:0] q_vec2_data;
   logic [2:0]  q_wb_register;
   logic [15:0] stall_count;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [4:0] NOP = 5'b11110;

   pipe_reg_execute dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .d_opcode(d_opcode), .d_reg1_data(d_reg1_data), .d_reg2_data(d_reg2_data),
      .d_immediate(d_immediate), .d_vec1_data(d_vec1_data), .d_vec2_data(d_vec2_data),
      .d_wb_register(d_wb_register),
      .out_valid(out_valid), .out_ready(out_ready),
      .q_opcode(q_opcode), .q_reg1_data(q_reg1_data), .q_reg2_data(q_reg2_data),
      .q_immediate(q_immediate), .q_vec1_data(q_vec1_data), .q_vec2_data(q_vec2_data),
      .q_wb_register(q_wb_register), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge. The falling edge is half a period later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n       = 1'b0;
      flush         = 1'b0;
      in_valid      = 1'b1;
      out_ready     = 1'b0;
      d_opcode      = 5'($urandom);
      d_reg1_data   = $urandom;
      d_reg2_data   = $urandom;
      d_immediate   = 8'($urandom);
      d_vec1_data   = {$urandom, $urandom};
      d_vec2_data   = {$urandom, $urandom};
      d_wb_register = 3'($urandom);

      // Reset held over several edges with input offered.
      repeat (3) step();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_opcode", 64'(q_opcode), 64'(NOP));
      check("rst_vec1", q_vec1_data, 64'd0);
      check("rst_stall", 64'(stall_count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);

      // Release reset between edges.
      in_valid = 1'b0;
      reset_n  = 1'b1;
      #1;
      check("rel_in_ready_pre", 64'(in_ready), 64'd0);
      step();
      check("rel_in_ready_post", 64'(in_ready), 64'd1);

      // Back-to-back streaming of opcodes 1..4.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         d_opcode    = 5'(i);
         d_reg1_data = 32'h0000_1000 + 32'(i);
         step();
         check("stream_opcode", 64'(q_opcode), 64'(i));
         check("stream_reg1", 64'(q_reg1_data), 64'(32'h0000_1000 + 32'(i)));
         check("stream_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      step();
      check("drain_valid", 64'(out_valid), 64'd0);
      check("drain_opcode", 64'(q_opcode), 64'(NOP));
      check("drain_reg1", 64'(q_reg1_data), 64'd0);
      check("drain_stall", 64'(stall_count), 64'd0);

      // Stall: hold opcode 5 for three edges while opcode 6 is offered.
      in_valid    = 1'b1;
      out_ready   = 1'b0;
      d_opcode    = 5'd5;
      d_reg1_data = 32'hDEADBEEF;
      step();
      check("stall_load", 64'(q_opcode), 64'd5);
      d_opcode    = 5'd6;
      d_reg1_data = 32'hCAFE0006;
      step();
`ifdef PIPE_REG_EXECUTE_SKID_EN
      in_valid = 1'b0;
`endif
      repeat (2) step();
      check("stall_opcode", 64'(q_opcode), 64'd5);
      check("stall_reg1", 64'(q_reg1_data), 64'hDEADBEEF);
      check("stall_count3", 64'(stall_count), 64'd3);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("release_opcode", 64'(q_opcode), 64'd6);
      check("release_reg1", 64'(q_reg1_data), 64'hCAFE0006);
      check("release_stall", 64'(stall_count), 64'd3);
      step();
      check("release_empty", 64'(out_valid), 64'd0);

      // Flush while opcode 7 is held and opcode 8 is pending.
      in_valid  = 1'b1;
      out_ready = 1'b0;
      d_opcode  = 5'd7;
      step();
      check("flush_load", 64'(q_opcode), 64'd7);
      d_opcode = 5'd8;
      flush    = 1'b1;
      #1;
      check("flush_in_ready", 64'(in_ready), 64'd0);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_opcode", 64'(q_opcode), 64'(NOP));
      check("flush_reg1", 64'(q_reg1_data), 64'd0);
      check("flush_stall", 64'(stall_count), 64'd3);
      step();
      check("flush_no_accept", 64'(out_valid), 64'd0);

      // Saturation: count from 3 up to 16'hFFFF, then hold.
      in_valid = 1'b1;
      d_opcode = 5'd9;
      step();
      in_valid = 1'b0;
      check("sat_load", 64'(q_opcode), 64'd9);
      repeat (65531) step();
      check("sat_fffe", 64'(stall_count), 64'hFFFE);
      step();
      check("sat_ffff", 64'(stall_count), 64'hFFFF);
      repeat (4) step();
      check("sat_hold", 64'(stall_count), 64'hFFFF);
      check("sat_opcode", 64'(q_opcode), 64'd9);

      // Asynchronous reset between edges during a stall.
      #2;
      reset_n = 1'b0;
      #1;
      check("areset_valid", 64'(out_valid), 64'd0);
      check("areset_opcode", 64'(q_opcode), 64'(NOP));
      check("areset_reg1", 64'(q_reg1_data), 64'd0);
      check("areset_stall", 64'(stall_count), 64'd0);
      check("areset_in_ready", 64'(in_ready), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
